// File: rtl/mem_alu_pkg.sv
// Shared ALU mode encodings and default widths for mem_alu_core.
package mem_alu_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOT  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_SHR  = 4'd8,
    ALU_INC  = 4'd9,
    ALU_DEC  = 4'd10
  } alu_mode_e;

endpackage

// File: rtl/mem_alu_core_alu.sv
// Combinational unsigned ALU; carry is carry-out for add/inc, borrow for sub/dec.
module alu_unit
  import mem_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [3:0]            mode_i,
  output logic [DATA_WIDTH-1:0] s_o,
  output logic                  zero_o,
  output logic                  carry_o
);

  localparam logic [DATA_WIDTH:0] ONE = {{DATA_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH:0] a_ext;
  logic [DATA_WIDTH:0] b_ext;
  logic [DATA_WIDTH:0] res_d;
  logic                arith_d;

  assign a_ext = {1'b0, a_i};
  assign b_ext = {1'b0, b_i};

  // The extra top bit holds carry/borrow; only arithmetic modes expose it.
  always_comb begin
    res_d   = '0;
    arith_d = 1'b0;
    case (mode_i)
      ALU_PASS: res_d = a_ext;
      ALU_ADD:  begin res_d = a_ext + b_ext; arith_d = 1'b1; end
      ALU_SUB:  begin res_d = a_ext - b_ext; arith_d = 1'b1; end
      ALU_AND:  res_d = {1'b0, a_i & b_i};
      ALU_OR:   res_d = {1'b0, a_i | b_i};
      ALU_XOR:  res_d = {1'b0, a_i ^ b_i};
      ALU_NOT:  res_d = {1'b0, ~a_i};
      ALU_SHL:  res_d = {1'b0, a_i << 1};
      ALU_SHR:  res_d = {1'b0, a_i >> 1};
      ALU_INC:  begin res_d = a_ext + ONE; arith_d = 1'b1; end
      ALU_DEC:  begin res_d = a_ext - ONE; arith_d = 1'b1; end
      default:  res_d = '0;
    endcase
  end

  assign s_o     = res_d[DATA_WIDTH-1:0];
  assign carry_o = arith_d & res_d[DATA_WIDTH];
  assign zero_o  = (s_o == '0);

endmodule

// File: rtl/mem_alu_core.sv
// Single-port synchronous RAM on a tristate bus plus combinational ALU.
// Define MEM_RESET_EN to clear every memory word on a reset edge.
module mem_alu_core
  import mem_alu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  logic [DATA_WIDTH-1:0] data,
  input  logic                  cs_input,
  input  logic                  we,
  input  logic                  oe,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            aluMode,
  output logic [DATA_WIDTH-1:0] s,
  output logic                  zero,
  output logic                  carry
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  drive_en;

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MEM_RESET_EN
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_WIDTH'(i)] <= '0;
      end
`endif
    end else if (cs_input && we) begin
      mem_q[addr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (cs_input && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  // Write enable wins over output enable so a write never fights the bus.
  assign drive_en = cs_input && oe && !we;
  assign data     = drive_en ? rdata_q : 'z;

  alu_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a_i    (a),
    .b_i    (b),
    .mode_i (aluMode),
    .s_o    (s),
    .zero_o (zero),
    .carry_o(carry)
  );

endmodule

// File: tb/tb_mem_alu_core.sv
// Self-checking bench for mem_alu_core: directed cases plus random RAM/ALU traffic.
module tb_mem_alu_core;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  wire  logic [7:0] data_bus;
  logic       cs_input;
  logic       we;
  logic       oe;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] aluMode;
  logic [7:0] s;
  logic       zero;
  logic       carry;

  logic       tb_drv_en;
  logic [7:0] tb_drv_val;

  int n_checks;
  int n_pass;

  logic [7:0] mdl_mem   [256];
  bit         mdl_valid [256];
  int         written_q [$];

  assign data_bus = tb_drv_en ? tb_drv_val : 'z;

  mem_alu_core #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data    (data_bus),
    .cs_input(cs_input),
    .we      (we),
    .oe      (oe),
    .a       (a),
    .b       (b),
    .aluMode (aluMode),
    .s       (s),
    .zero    (zero),
    .carry   (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ad, input int val);
    addr = 8'(ad); cs_input = 1'b1; we = 1'b1; oe = 1'b0;
    tb_drv_en = 1'b1; tb_drv_val = 8'(val);
    tick();
    mdl_mem[ad] = 8'(val);
    if (!mdl_valid[ad]) written_q.push_back(ad);
    mdl_valid[ad] = 1'b1;
    tb_drv_en = 1'b0; cs_input = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string tag, input int ad);
    addr = 8'(ad); cs_input = 1'b1; we = 1'b0; oe = 1'b1;
    tb_drv_en = 1'b0;
    tick();
    check(tag, {24'h0, data_bus}, {24'h0, mdl_mem[ad]});
  endtask

  // Undriven check: bench drives 0 while the DUT should be silent; a DUT
  // driving its (non-zero) read register would corrupt the bus value.
  task automatic expect_silent(input string tag);
    tb_drv_en = 1'b1; tb_drv_val = 8'h00;
    #1;
    check(tag, {24'h0, data_bus}, 32'h0);
    tb_drv_en = 1'b0;
  endtask

  // Reference ALU from the operation table, using plain integer arithmetic.
  function automatic void alu_ref(input int mode, input int av, input int bv,
                                  output int rs, output int rc);
    int r;
    rc = 0;
    case (mode)
      0:  r = av;
      1:  begin r = av + bv; rc = (r > 255) ? 1 : 0; end
      2:  begin r = av - bv; rc = (av < bv) ? 1 : 0; end
      3:  r = av & bv;
      4:  r = av | bv;
      5:  r = av ^ bv;
      6:  r = 255 - av;
      7:  r = av * 2;
      8:  r = av / 2;
      9:  begin r = av + 1; rc = (av == 255) ? 1 : 0; end
      10: begin r = av - 1; rc = (av == 0) ? 1 : 0; end
      default: r = 0;
    endcase
    rs = (r + 256) % 256;
  endfunction

  task automatic alu_chk(input string tag, input int mode, input int av, input int bv);
    int es, ec;
    aluMode = 4'(mode); a = 8'(av); b = 8'(bv);
    #1;
    alu_ref(mode, av, bv, es, ec);
    check({tag, ".s"}, {24'h0, s}, es);
    check({tag, ".c"}, {31'h0, carry}, ec);
    check({tag, ".z"}, {31'h0, zero}, (es == 0) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
`ifdef MEM_RESET_EN
    for (int i = 0; i < 256; i++) begin
      mdl_mem[i] = 8'h00;
      if (!mdl_valid[i]) written_q.push_back(i);
      mdl_valid[i] = 1'b1;
    end
`endif
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    for (int i = 0; i < 256; i++) begin
      mdl_mem[i] = 8'h00; mdl_valid[i] = 1'b0;
    end
    rst = 1'b1; addr = 8'h00; cs_input = 1'b1; we = 1'b0; oe = 1'b1;
    a = 8'h00; b = 8'h00; aluMode = 4'd0;
    tb_drv_en = 1'b0; tb_drv_val = 8'h00;
    do_reset();
    tick();
    check("reset_bus", {24'h0, data_bus}, 32'h0);
    rst = 1'b0;

    wr(8'h00, 8'h10); wr(8'h01, 8'h1C); wr(8'h02, 8'h30);
    rd("rd00", 8'h00); rd("rd01", 8'h01); rd("rd02", 8'h02);

    // rdata register now 0x30; each of these must leave the bus undriven
    addr = 8'h02; cs_input = 1'b1; we = 1'b0; oe = 1'b0;
    tick();
    expect_silent("oe0_z");
    cs_input = 1'b0; oe = 1'b1;
    expect_silent("cs0_z");
    wr(8'h03, 8'h00);
    addr = 8'h03; cs_input = 1'b1; we = 1'b1; oe = 1'b1;
    expect_silent("we_oe_z");
    cs_input = 1'b0; we = 1'b0;

    addr = 8'h01; cs_input = 1'b0; we = 1'b1; oe = 1'b0;
    tb_drv_en = 1'b1; tb_drv_val = 8'hAA;
    tick();
    tb_drv_en = 1'b0; we = 1'b0;
    rd("cs0_nowrite", 8'h01);

    alu_chk("add1", 1, 8'h01, 8'h0B);
    alu_chk("add2", 1, 8'hFF, 8'h01);
    alu_chk("sub1", 2, 8'h0B, 8'h01);
    alu_chk("sub2", 2, 8'h00, 8'h01);
    alu_chk("shr",  8, 8'h81, 8'h00);
    alu_chk("inc",  9, 8'hFF, 8'h00);
    alu_chk("dec", 10, 8'h00, 8'h00);
    alu_chk("m15", 15, 8'hFF, 8'hFF);

    wr(8'hFF, 8'h5A); wr(8'h20, 8'h0B);
    rd("rdFF", 8'hFF); rd("rd20", 8'h20);
    wr(8'h21, 8'h77);
    rd("rd21_new", 8'h21);

    rd("rd20_pre", 8'h20);
    addr = 8'h20; cs_input = 1'b1; we = 1'b0; oe = 1'b1;
    do_reset();
    check("rst_mid_read", {24'h0, data_bus}, 32'h0);
    we = 1'b1; tb_drv_en = 1'b1; tb_drv_val = 8'hE7;
    do_reset();
    rst = 1'b0; tb_drv_en = 1'b0; we = 1'b0; cs_input = 1'b0;
    rd("rst_nowrite", 8'h20);
    rd("rst_keepFF", 8'hFF);

    for (int n = 0; n < 300; n++) begin
      int op, ad;
      op = $urandom_range(0, 3);
      case (op)
        0: wr($urandom_range(0, 255), $urandom_range(0, 255));
        1: if (written_q.size() > 0) begin
             ad = written_q[$urandom_range(0, written_q.size() - 1)];
             rd("rnd_rd", ad);
           end
        2: alu_chk("rnd_alu", $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
        default: begin
          addr = 8'($urandom_range(0, 255)); cs_input = 1'b0; we = 1'b1; oe = 1'b0;
          tb_drv_en = 1'b1; tb_drv_val = 8'($urandom_range(0, 255));
          tick();
          tb_drv_en = 1'b0; we = 1'b0;
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
